mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/rr_arb2.sv | 26 ++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: FSM encoding,
// fetch opcode and default geometry.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  localparam logic [5:0] FETCH_OP    = 6'b100011;
  localparam int         DEF_TIMEOUT = 15;
  localparam int         DEF_ADDR_W  = 9;

  // Requester bit positions in the arbiter request/grant vectors
  localparam int D_IDX = 0;
  localparam int F_IDX = 1;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. The pointer remembers which port to favour
// next and only moves when the owner signals completion.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       served_fetch,
  output logic [1:0] gnt
);
  logic prio_d_q, prio_d_d;

  always_comb begin
    gnt        = '0;
    gnt[D_IDX] = req[D_IDX] & (prio_d_q | ~req[F_IDX]);
    gnt[F_IDX] = req[F_IDX] & (~prio_d_q | ~req[D_IDX]);
    prio_d_d   = upd ? served_fetch : prio_d_q;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) prio_d_q <= 1'b1;
    else      prio_d_q <= prio_d_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM between a fetch port and a data port: IDLE grants and latches
// a command, BUSY waits for ram_done (with timeout), RESP pulses the ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [31:0]       d_wdata,
  input  logic [5:0]        d_op,
  output logic              d_ack,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rw,
  output logic [31:0]       ram_wdata,
  output logic [5:0]        ram_op,
  output logic              ram_load_inst,
  input  logic [31:0]       ram_dout,
  input  logic              ram_done
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_f_q, gnt_f_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        gnt;

  rr_arb2 u_arb (
    .clk          (clk),
    .clr          (clr),
    .req          ({f_req, d_req}),
    .upd          (state_q == RESP),
    .served_fetch (gnt_f_q),
    .gnt          (gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_f_d = gnt_f_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (f_req || d_req) begin
        state_d = BUSY;
        cnt_d   = '0;
        err_d   = 1'b0;
        gnt_f_d = (gnt == 2'b10);
        if (gnt == 2'b10) begin
          addr_d  = f_addr;
          rw_d    = 1'b0;
          wdata_d = '0;
          op_d    = FETCH_OP;
        end else begin
          addr_d  = d_addr;
          rw_d    = d_we;
          wdata_d = d_wdata;
          op_d    = d_op;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // A completion in the final allowed cycle still counts as success
        if (ram_done) begin
          state_d = RESP;
          if (!rw_q) rdata_d = ram_dout;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_f_q <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      op_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_f_q <= gnt_f_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign ram_en        = (state_q == BUSY);
  assign f_ack         = (state_q == RESP) &  gnt_f_q;
  assign d_ack         = (state_q == RESP) & ~gnt_f_q;
  assign err           = (state_q == RESP) &  err_q;
  assign ram_load_inst = (state_q != IDLE) &  gnt_f_q;
  assign ram_addr      = addr_q;
  assign ram_rw        = rw_q;
  assign ram_wdata     = wdata_q;
  assign ram_op        = op_q;
  assign rdata         = rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand
// sequences for timeout, late completion and mid-transaction reset.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0, clr;
  logic        f_req, d_req, d_we, ram_done;
  logic [8:0]  f_addr, d_addr;
  logic [31:0] d_wdata, ram_dout;
  logic [5:0]  d_op;
  logic        f_ack, d_ack, err, ram_en, ram_rw, ram_load_inst;
  logic [31:0] rdata, ram_wdata;
  logic [8:0]  ram_addr;
  logic [5:0]  ram_op;

  int err_cnt = 0;
  int chk_cnt = 0;

  mem_port_arbiter dut (
    .clk(clk), .clr(clr),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_op(d_op),
    .d_ack(d_ack), .rdata(rdata), .err(err),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_wdata(ram_wdata),
    .ram_op(ram_op), .ram_load_inst(ram_load_inst),
    .ram_dout(ram_dout), .ram_done(ram_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic        f_req, d_req;
    logic [8:0]  f_addr, d_addr;
    logic        d_we;
    logic [31:0] d_wdata;
    logic [5:0]  d_op;
    logic [31:0] ram_dout;
    logic        ram_done;
    logic        e_fack, e_dack, e_err, e_en, e_li;
    logic [8:0]  e_addr;
    logic [5:0]  e_op;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, logic fr, logic dr, logic [8:0] fa, logic [8:0] da,
                              logic we, logic [31:0] wd, logic [5:0] op, logic [31:0] dout,
                              logic done, logic efa, logic eda, logic eer, logic een, logic eli,
                              logic [8:0] ea, logic [5:0] eop, logic [31:0] erd);
    vec_t v;
    v.rst = rst; v.f_req = fr; v.d_req = dr; v.f_addr = fa; v.d_addr = da;
    v.d_we = we; v.d_wdata = wd; v.d_op = op; v.ram_dout = dout; v.ram_done = done;
    v.e_fack = efa; v.e_dack = eda; v.e_err = eer; v.e_en = een; v.e_li = eli;
    v.e_addr = ea; v.e_op = eop; v.e_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0; f_req = 1'b0; d_req = 1'b0; ram_done = 1'b0;
    tick();
    #2 clr = 1'b1;
  endtask

  // Drives a data-port request and waits for d_ack; done_at=N raises ram_done
  // during the N-th BUSY cycle, 0 never raises it.
  task automatic run_data(input int done_at, output int n_en, output bit acked,
                          output logic e, output logic [31:0] rd);
    n_en = 0; acked = 1'b0; e = 1'b0; rd = '0;
    d_req = 1'b1;
    for (int i = 0; i < 40 && !acked; i++) begin
      tick();
      if (d_ack) begin
        acked = 1'b1; e = err; rd = rdata;
        chk("f_ack during d_ack", f_ack, 1'b0);
        chk("ram_en in RESP", ram_en, 1'b0);
      end else if (ram_en) begin
        n_en++;
        if (done_at != 0 && n_en == done_at) ram_done = 1'b1;
      end
    end
    d_req = 1'b0; ram_done = 1'b0;
  endtask

  localparam logic [5:0]  DOP  = 6'b100000;
  localparam logic [31:0] DOUT = 32'h1234_5678;

  initial begin
    int          n_en;
    bit          acked;
    logic        e;
    logic [31:0] rd;

    f_req = 0; d_req = 0; f_addr = 0; d_addr = 0; d_we = 0; d_wdata = 0; d_op = 0;
    ram_dout = 0; ram_done = 0;

    // Single fetch with completion on the 2nd BUSY cycle
    tbl.push_back(mk(1, 1,0, 9'd4,0, 0,0,0, 0,0,           0,0,0,1,1, 9'd4,FETCH_OP,0));
    tbl.push_back(mk(0, 1,0, 9'd4,0, 0,0,0, 0,0,           0,0,0,1,1, 9'd4,FETCH_OP,0));
    tbl.push_back(mk(0, 1,0, 9'd4,0, 0,0,0, 32'h8C010004,1, 1,0,0,0,1, 9'd4,FETCH_OP,32'h8C010004));
    tbl.push_back(mk(0, 0,0, 9'd4,0, 0,0,0, 0,0,           0,0,0,0,0, 9'd4,FETCH_OP,32'h8C010004));
    // Both ports held from reset: grants alternate D,F,D,F,D,F; ram_done held high
    for (int k = 0; k < 6; k++) begin
      logic        fe;
      logic [8:0]  ea;
      logic [5:0]  eo;
      logic [31:0] rp;
      fe = (k % 2) == 1;
      ea = fe ? 9'd8 : 9'd50;
      eo = fe ? FETCH_OP : DOP;
      rp = (k == 0) ? 32'h0 : DOUT;
      tbl.push_back(mk(k == 0, 1,1, 9'd8,9'd50, 0,0,DOP, DOUT,1, 0,0,0,1,fe,   ea,eo,rp));
      tbl.push_back(mk(0,      1,1, 9'd8,9'd50, 0,0,DOP, DOUT,1, fe,!fe,0,0,fe, ea,eo,DOUT));
      tbl.push_back(mk(0,      1,1, 9'd8,9'd50, 0,0,DOP, DOUT,1, 0,0,0,0,0,    ea,eo,DOUT));
    end

    // Reset state, sampled while clr is still low
    clr = 1'b0;
    #2;
    chk("rst ram_en", ram_en, 0);   chk("rst f_ack", f_ack, 0);
    chk("rst d_ack", d_ack, 0);     chk("rst err", err, 0);
    chk("rst ram_addr", ram_addr, 0); chk("rst ram_op", ram_op, 0);
    chk("rst rdata", rdata, 0);     chk("rst ram_li", ram_load_inst, 0);
    tick();
    #2 clr = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      f_req = tbl[i].f_req; d_req = tbl[i].d_req; f_addr = tbl[i].f_addr;
      d_addr = tbl[i].d_addr; d_we = tbl[i].d_we; d_wdata = tbl[i].d_wdata;
      d_op = tbl[i].d_op; ram_dout = tbl[i].ram_dout; ram_done = tbl[i].ram_done;
      tick();
      chk($sformatf("v%0d f_ack", i), f_ack, tbl[i].e_fack);
      chk($sformatf("v%0d d_ack", i), d_ack, tbl[i].e_dack);
      chk($sformatf("v%0d err", i), err, tbl[i].e_err);
      chk($sformatf("v%0d ram_en", i), ram_en, tbl[i].e_en);
      chk($sformatf("v%0d ram_load_inst", i), ram_load_inst, tbl[i].e_li);
      chk($sformatf("v%0d ram_addr", i), ram_addr, tbl[i].e_addr);
      chk($sformatf("v%0d ram_op", i), ram_op, tbl[i].e_op);
      chk($sformatf("v%0d rdata", i), rdata, tbl[i].e_rdata);
    end
    f_req = 1'b0; d_req = 1'b0; ram_done = 1'b0;
    tick();

    // Write that never completes: 15 BUSY cycles then d_ack with err
    d_we = 1'b1; d_addr = 9'd100; d_wdata = 32'hDEADBEEF; d_op = 6'b101011;
    run_data(0, n_en, acked, e, rd);
    chk("timeout acked", acked, 1'b1);
    chk("timeout ram_en cycles", n_en, 15);
    chk("timeout err", e, 1'b1);
    chk("timeout rdata kept", rd, DOUT);
    chk("timeout ram_rw", ram_rw, 1'b1);
    chk("timeout ram_wdata", ram_wdata, 32'hDEADBEEF);
    chk("timeout ram_addr", ram_addr, 9'd100);
    tick();
    chk("after timeout err", err, 1'b0);
    chk("after timeout d_ack", d_ack, 1'b0);

    // Read completing on the 15th BUSY cycle wins over the timeout
    d_we = 1'b0; d_addr = 9'd7; ram_dout = 32'hCAFEF00D;
    run_data(15, n_en, acked, e, rd);
    chk("late done acked", acked, 1'b1);
    chk("late done ram_en cycles", n_en, 15);
    chk("late done err", e, 1'b0);
    chk("late done rdata", rd, 32'hCAFEF00D);
    tick();

    // Data was served last, so fetch wins; reset mid-BUSY then data wins again
    f_addr = 9'd12; d_addr = 9'd60; f_req = 1'b1; d_req = 1'b1;
    tick();
    chk("rr fetch after data", ram_load_inst, 1'b1);
    chk("rr fetch addr", ram_addr, 9'd12);
    tick();
    #2 clr = 1'b0;
    #1;
    chk("midrst ram_en", ram_en, 0);     chk("midrst ram_addr", ram_addr, 0);
    chk("midrst ram_li", ram_load_inst, 0); chk("midrst rdata", rdata, 0);
    chk("midrst ram_op", ram_op, 0);     chk("midrst ram_wdata", ram_wdata, 0);
    chk("midrst ram_rw", ram_rw, 0);     chk("midrst err", err, 0);
    tick();
    chk("midrst f_ack", f_ack, 0);
    chk("midrst d_ack", d_ack, 0);
    #2 clr = 1'b1;
    tick();
    chk("post-rst data prio li", ram_load_inst, 1'b0);
    chk("post-rst data addr", ram_addr, 9'd60);
    chk("post-rst ram_en", ram_en, 1'b1);
    ram_done = 1'b1; ram_dout = 32'h0BAD_CAFE;
    tick();
    chk("post-rst d_ack", d_ack, 1'b1);
    chk("post-rst f_ack", f_ack, 1'b0);
    chk("post-rst rdata", rdata, 32'h0BAD_CAFE);
    f_req = 1'b0; d_req = 1'b0; ram_done = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
